// File: rtl/cache_line_writeback.sv
// Dirty-line eviction: captures a whole cache line and writes it to memory one word per accepted beat.
// Optional build macro CACHE_WB_DIRTY_MASK_EN restricts the writes to the words flagged in dirty_i.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; all outputs zero
//   S_WRITE | presenting word idx_q; advances on mem_ack
//   S_DONE  | one-cycle done pulse, then back to S_IDLE
module cache_line_writeback #(
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                                clk,
    input  logic                                clr,
    input  logic                                start,
    input  logic [WORD_SIZE-1:0]                addr_i,
    input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_i,
    input  logic [WORDS_PER_LINE-1:0]           dirty_i,
    input  logic                                mem_ack,
    output logic                                mem_we,
    output logic [WORD_SIZE-1:0]                mem_addr,
    output logic [WORD_SIZE-1:0]                mem_data,
    output logic                                busy,
    output logic                                done
);

    localparam int LINE_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFS_BITS  = LINE_BITS + 2;
    localparam logic [LINE_BITS-1:0] LAST_IDX  = LINE_BITS'(WORDS_PER_LINE - 1);
    localparam logic [WORD_SIZE-1:0] BASE_MASK = {WORD_SIZE{1'b1}} << OFS_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                                   state_q, state_d;
    logic [LINE_BITS-1:0]                     idx_q, idx_d;
    logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0] line_q, line_d;
    logic [WORD_SIZE-1:0]                     base_q, base_d;
    logic                                     capture;

`ifdef CACHE_WB_DIRTY_MASK_EN
    logic [WORDS_PER_LINE-1:0] mask_q, mask_d;
    logic                      first_found, next_found;
    logic [LINE_BITS-1:0]      first_pos, next_pos;

    // Lowest set bit of mask at or above lo; found=0 when none remains.
    function automatic void find_set(input  logic [WORDS_PER_LINE-1:0] mask,
                                     input  int                        lo,
                                     output logic                      found,
                                     output logic [LINE_BITS-1:0]      pos);
        found = 1'b0;
        pos   = '0;
        for (int k = WORDS_PER_LINE - 1; k >= 0; k--) begin
            if (mask[k] && (k >= lo)) begin
                found = 1'b1;
                pos   = LINE_BITS'(k);
            end
        end
    endfunction

    always_comb begin
        find_set(dirty_i, 0, first_found, first_pos);
        find_set(mask_q, int'(idx_q) + 1, next_found, next_pos);
    end
`else
    logic unused_dirty;
    assign unused_dirty = ^dirty_i;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
`ifdef CACHE_WB_DIRTY_MASK_EN
                    // An all-clean line still reports completion, without any write.
                    state_d = first_found ? S_WRITE : S_DONE;
                    idx_d   = first_pos;
`else
                    state_d = S_WRITE;
                    idx_d   = '0;
`endif
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
`ifdef CACHE_WB_DIRTY_MASK_EN
                    state_d = next_found ? S_WRITE : S_DONE;
                    idx_d   = next_pos;
`else
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        line_d = line_q;
        base_d = base_q;
        if (capture) begin
            line_d = line_i;
            base_d = addr_i & BASE_MASK;
        end
    end

`ifdef CACHE_WB_DIRTY_MASK_EN
    always_comb begin
        mask_d = mask_q;
        if (capture) begin
            mask_d = dirty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            line_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            base_q  <= base_d;
        end
    end

    // Outputs decode registered state only; address and data are forced to zero outside WRITE.
    assign mem_we   = (state_q == S_WRITE);
    assign busy     = (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);
    assign mem_addr = mem_we ? (base_q + WORD_SIZE'({idx_q, 2'b00})) : '0;
    assign mem_data = mem_we ? line_q[idx_q] : '0;

endmodule

// File: tb/tb_cache_line_writeback.sv
// Scoreboard bench for cache_line_writeback: expected beats and done pulses are queued when a
// writeback is launched and checked, with their cycle numbers, as the DUT produces them.
module tb_cache_line_writeback;

    localparam int WS  = 32;
    localparam int WPL = 8;

    typedef struct {
        logic [WS-1:0] addr;
        logic [WS-1:0] data;
        int            cyc;
    } beat_t;

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic [WS-1:0]     addr_i;
    logic [WS*WPL-1:0] line_i;
    logic [WPL-1:0]    dirty_i;
    logic              mem_ack;
    logic              mem_we;
    logic [WS-1:0]     mem_addr;
    logic [WS-1:0]     mem_data;
    logic              busy;
    logic              done;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    beat_t beat_q[$];
    int    done_q[$];

    cache_line_writeback #(.WORD_SIZE(WS), .WORDS_PER_LINE(WPL)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .addr_i  (addr_i),
        .line_i  (line_i),
        .dirty_i (dirty_i),
        .mem_ack (mem_ack),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WS*WPL-1:0] make_line(input logic [WS-1:0] seed);
        logic [WS*WPL-1:0] l;
        for (int k = 0; k < WPL; k++) l[k*WS +: WS] = seed + WS'(k);
        return l;
    endfunction

    task automatic push_beat(input logic [WS-1:0] a, input logic [WS-1:0] d, input int c);
        beat_t b;
        b.addr = a;
        b.data = d;
        b.cyc  = c;
        beat_q.push_back(b);
    endtask

    // Full line, mem_ack held high, start sampled in cycle t0.
    task automatic push_run(input logic [WS-1:0] base, input logic [WS*WPL-1:0] l, input int t0);
        for (int k = 0; k < WPL; k++) push_beat(base + WS'(k * 4), l[k*WS +: WS], t0 + 1 + k);
        done_q.push_back(t0 + WPL + 1);
    endtask

    // Monitor: every presented word must match the head of the scoreboard; accepted words
    // must land on their expected cycle; outside WRITE address and data stay zero.
    always @(negedge clk) begin
        if (!clr) begin
            if (mem_we) begin
                if (beat_q.size() == 0) begin
                    check_eq("unexpected_beat", {31'b0, mem_we}, 32'd0);
                end else begin
                    check_eq("mem_addr", mem_addr, beat_q[0].addr);
                    check_eq("mem_data", mem_data, beat_q[0].data);
                    if (mem_ack) begin
                        check_eq("beat_cycle", cyc, beat_q[0].cyc);
                        void'(beat_q.pop_front());
                    end
                end
            end else begin
                check_eq("idle_addr", mem_addr, 32'd0);
                check_eq("idle_data", mem_data, 32'd0);
            end
            if (done) begin
                if (done_q.size() == 0) check_eq("unexpected_done", {31'b0, done}, 32'd0);
                else check_eq("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    initial begin
        int t0;
        clr     = 1'b1;
        start   = 1'b0;
        mem_ack = 1'b1;
        addr_i  = '0;
        line_i  = '0;
        dirty_i = '1;
        repeat (3) step();
        clr = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_data", mem_data, 32'd0);

        // Basic full-line writeback with busy window check.
        step();
        t0     = cyc;
        start  = 1'b1;
        addr_i = 32'h0000_1234;
        line_i = make_line(32'h1000);
        push_run(32'h1220, line_i, t0);
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            @(negedge clk);
            check_eq("t1_busy", {31'b0, busy}, {31'b0, (c <= 8)});
            check_eq("t1_done", {31'b0, done}, {31'b0, (c == 9)});
        end

        // mem_ack low for the three cycles word 2 is first presented.
        step();
        t0     = cyc;
        start  = 1'b1;
        addr_i = 32'h0000_1234;
        line_i = make_line(32'h1000);
        for (int k = 0; k < WPL; k++)
            push_beat(32'h1220 + WS'(k * 4), 32'h1000 + WS'(k), t0 + 1 + k + ((k >= 2) ? 3 : 0));
        done_q.push_back(t0 + 12);
        for (int c = 1; c <= 13; c++) begin
            step();
            start   = 1'b0;
            mem_ack = !(c >= 3 && c <= 5);
        end
        mem_ack = 1'b1;

        // start re-asserted mid-write and during DONE must be ignored.
        step();
        t0     = cyc;
        start  = 1'b1;
        addr_i = 32'h0000_1234;
        line_i = make_line(32'h1000);
        push_run(32'h1220, line_i, t0);
        for (int c = 1; c <= 12; c++) begin
            step();
            start = (c == 3 || c == 9);
            if (start) begin
                addr_i = 32'hABCD_0040;
                line_i = make_line(32'hDEAD_0000);
            end
        end

        // clr in cycle 4 drops the line with no done pulse; a new start begins at word 0.
        step();
        t0     = cyc;
        start  = 1'b1;
        addr_i = 32'h0000_1234;
        line_i = make_line(32'h2000);
        for (int k = 0; k < 3; k++) push_beat(32'h1220 + WS'(k * 4), 32'h2000 + WS'(k), t0 + 1 + k);
        for (int c = 1; c <= 4; c++) begin
            step();
            start = 1'b0;
            if (c == 4) begin
                clr     = 1'b1;
                mem_ack = 1'b0;
            end
        end
        step();
        clr     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        check_eq("clr_mem_we", {31'b0, mem_we}, 32'd0);
        check_eq("clr_busy", {31'b0, busy}, 32'd0);
        check_eq("clr_done", {31'b0, done}, 32'd0);
        check_eq("clr_addr", mem_addr, 32'd0);
        check_eq("clr_data", mem_data, 32'd0);
        repeat (12) step();
        t0     = cyc;
        start  = 1'b1;
        addr_i = 32'h0000_5678;
        line_i = make_line(32'h3000);
        push_run(32'h5660, line_i, t0);
        step();
        start = 1'b0;
        repeat (10) step();

        // start held high: captures at cycles 0 and 10 with the data present then.
        step();
        t0 = cyc;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) step();
            start  = 1'b1;
            addr_i = 32'h0000_4000 + WS'(c * 32'h100);
            line_i = make_line(32'hB000_0000 | WS'(c << 8));
            if (c == 0 || c == 10) push_run(addr_i, line_i, t0 + c);
        end
        step();
        start = 1'b0;
        repeat (12) step();

`ifdef CACHE_WB_DIRTY_MASK_EN
        // Sparse mask: words 0, 2 and 7 only, back to back.
        step();
        t0      = cyc;
        start   = 1'b1;
        addr_i  = 32'h0000_1234;
        line_i  = make_line(32'h1000);
        dirty_i = 8'b1000_0101;
        push_beat(32'h1220, 32'h1000, t0 + 1);
        push_beat(32'h1228, 32'h1002, t0 + 2);
        push_beat(32'h123C, 32'h1007, t0 + 3);
        done_q.push_back(t0 + 4);
        step();
        start   = 1'b0;
        dirty_i = '1;
        repeat (6) step();

        // Clean line: done in cycle 1, never any write.
        t0      = cyc;
        start   = 1'b1;
        dirty_i = '0;
        done_q.push_back(t0 + 1);
        step();
        start   = 1'b0;
        dirty_i = '1;
        repeat (4) step();
`endif

        check_eq("beats_left", beat_q.size(), 32'd0);
        check_eq("dones_left", done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
